reg_status_ctrl: RTL and testbench
==================================

# reg_status_ctrl

Rename/commit controller for the 8-entry architectural register file. Each cycle it accepts up to four in-order dispatch renames and up to three in-order commits. It owns the per-register busy bits and ROB tags, and drives the register file's rename-tag and data write ports. It sits between the dispatch/ROB logic and the register file, and is the only block that sequences writes into that file.

## Interface
- `NREG`, 8: architectural registers; fixed, indexed by 3 bits.
- `TAGW`, 6: ROB tag width.
- `DW`, 16: register data width.
- `clk` in 1: single clock, all state on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `disp_valid_X` in 1, X∈{A,B,C,D}: dispatch slot X renames a destination; A oldest, D youngest.
- `disp_waddr_X` in 3: destination arch register for slot X.
- `disp_loc_X` in TAGW: ROB tag allocated to slot X.
- `disp_ready` out 1: dispatch accepted this cycle.
- `cmt_valid_k` in 1, k∈{0,1,2}: commit port k retires; 0 oldest, 2 youngest.
- `cmt_waddr_k` in 3, `cmt_loc_k` in TAGW, `cmt_data_k` in DW: retiring destination, tag, result.
- `flush` in 1: mispredict/trap recovery request.
- `rob_wen_X` out 1, `rob_waddr_X` out 3, `rob_loc_X` out TAGW: register-file tag write port X.
- `wen_k` out 1, `waddr_k` out 3, `wdata_k` out DW: register-file data write port k.
- `busy` out NREG: per-register busy vector (registered).
- `tag_flat` out NREG*TAGW: current tag per register; register r occupies bits [r*TAGW +: TAGW].
- `busy_count` out 4: popcount of `busy`.
- `flushing` out 1: high while in state FLUSH.

## Operation
- States: RUN, FLUSH. Reset enters RUN.
- `disp_ready` = (state==RUN) & !flush. This is combinational, so a same-cycle flush kills dispatch.
- `rob_wen_X` = `disp_valid_X` & `disp_ready`. Waddr and loc pass straight through.
- Dispatch accept: `busy[r]` is set and `tag[r]` is loaded from the youngest accepted slot targeting r. D beats C beats B beats A.
- Commit: `wen_k` = `cmt_valid_k` in every state, including during flush and FLUSH. Retirements precede the flush, so they always update architectural data. Waddr and wdata pass straight through.
- Commit clear: `busy[r]` clears when some valid commit has waddr r and loc == `tag[r]`, and no accepted dispatch targets r in the same cycle. A same-cycle dispatch wins: busy stays set and the tag becomes the new tag.
- A commit whose loc ≠ `tag[r]` writes data but leaves busy and tag unchanged (a younger rename is pending).
- Multiple commits to the same r in one cycle: all are checked for a tag match, and the data of the youngest port wins. This matches the register file's port priority.
- Flush: in the cycle `flush` is high, the next state is FLUSH and all `busy` bits clear at the next edge. Tags are retained but are don't-care.
- FLUSH lasts exactly one cycle (`disp_ready`=0), then the block returns to RUN. A flush asserted while in FLUSH extends FLUSH by one cycle per asserted cycle.
- Register 0 has no special behaviour.

## Timing
- Write-port outputs are combinational from inputs and state. The register file samples them at the same edge.
- `busy`, `tag_flat` and `flushing` update one cycle after the accepting/committing edge. `busy_count` is combinational from `busy`.
- Reset values: `busy`=0, all tags=0, state RUN, `flushing`=0, `busy_count`=0. `disp_ready`=1 when `flush`=0. All `rob_wen_X`/`wen_k`=0 when valids are low.
- Asynchronous reset mid-operation drops all in-flight state immediately. Outputs reach reset values without waiting for a clock edge.

## Structure
- Shared package: `NREG`, `TAGW`, `DW`, state enum {RUN, FLUSH}, and the `reg_idx_t` / `rob_tag_t` / `reg_data_t` typedefs. The dispatch unit and ROB import it too.
- One sub-module, `busy_tag_table`: 8× (busy, tag) storage with the set/clear/priority logic and the flush clear. The top level holds the FSM, the write-port gating and the popcount.

## Test plan
- Reset, then dispatch A:r3/tag5 → `rob_wen_A`=1, next cycle `busy[3]`=1, tag3=5, `busy_count`=1.
- Same cycle A:r2/tag7 and C:r2/tag9 → tag2=9. Then commit r2/tag7 → `wen_0`=1 writing data, `busy[2]` stays 1. Commit r2/tag9 → `busy[2]`=0.
- Commit r4/tag6 while D dispatches r4/tag11 in the same cycle → `busy[4]`=1, tag4=11, data written.
- Set `busy` for r1, r5, r6, then assert `flush` with `disp_valid_A`=1 → `rob_wen_A`=0. Next cycle `busy`=0, `flushing`=1, `disp_ready`=0. The cycle after, `disp_ready`=1.
- Commit ports 0 and 2 both target r7 (loc matches tag on port 0 only) → `wen_0`=`wen_2`=1, register file keeps port-2 data, `busy[7]`=0.
- Drop `rst_n` between edges with `busy`=0xFF → `busy` and `busy_count` go to 0 asynchronously.

Source files
------------

// File: rtl/reg_status_ctrl_pkg.sv
// Shared types and sizes for the rename/commit controller and its neighbours
// (dispatch unit, ROB, register file).
package reg_status_ctrl_pkg;

    localparam int NREG  = 8;
    localparam int TAGW  = 6;
    localparam int DW    = 16;
    localparam int NDISP = 4;   // dispatch slots, index 0 = A (oldest) .. 3 = D (youngest)
    localparam int NCMT  = 3;   // commit ports, index 0 = oldest .. 2 = youngest

    typedef logic [2:0]      reg_idx_t;
    typedef logic [TAGW-1:0] rob_tag_t;
    typedef logic [DW-1:0]   reg_data_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    function automatic logic [3:0] popcount(input logic [NREG-1:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < NREG; i++) begin
            cnt = cnt + 4'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/reg_status_ctrl_if.sv
// Dispatch, commit and register-file write-port bundle of the rename/commit controller.
// Slot/port arrays are indexed oldest-first (dispatch A..D = 0..3, commit 0..2).
interface reg_status_ctrl_if;
    import reg_status_ctrl_pkg::*;

    logic      [NDISP-1:0] disp_valid;
    reg_idx_t  [NDISP-1:0] disp_waddr;
    rob_tag_t  [NDISP-1:0] disp_loc;
    logic                  disp_ready;

    logic      [NCMT-1:0]  cmt_valid;
    reg_idx_t  [NCMT-1:0]  cmt_waddr;
    rob_tag_t  [NCMT-1:0]  cmt_loc;
    reg_data_t [NCMT-1:0]  cmt_data;

    logic                  flush;

    logic      [NDISP-1:0] rob_wen;
    reg_idx_t  [NDISP-1:0] rob_waddr;
    rob_tag_t  [NDISP-1:0] rob_loc;

    logic      [NCMT-1:0]  wen;
    reg_idx_t  [NCMT-1:0]  waddr;
    reg_data_t [NCMT-1:0]  wdata;

    logic [NREG-1:0]       busy;
    logic [NREG*TAGW-1:0]  tag_flat;
    logic [3:0]            busy_count;
    logic                  flushing;

    modport master (
        output disp_valid, disp_waddr, disp_loc,
        output cmt_valid, cmt_waddr, cmt_loc, cmt_data,
        output flush,
        input  disp_ready,
        input  rob_wen, rob_waddr, rob_loc,
        input  wen, waddr, wdata,
        input  busy, tag_flat, busy_count, flushing
    );

    modport slave (
        input  disp_valid, disp_waddr, disp_loc,
        input  cmt_valid, cmt_waddr, cmt_loc, cmt_data,
        input  flush,
        output disp_ready,
        output rob_wen, rob_waddr, rob_loc,
        output wen, waddr, wdata,
        output busy, tag_flat, busy_count, flushing
    );

endinterface

// File: rtl/reg_status_ctrl_busy_tag_table.sv
// Per-register busy bit and ROB tag storage: youngest dispatch sets, tag-matching
// commit clears, same-cycle dispatch beats commit, flush clears every busy bit.
module busy_tag_table
    import reg_status_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic     [NDISP-1:0]  set_en,
    input  reg_idx_t [NDISP-1:0]  set_idx,
    input  rob_tag_t [NDISP-1:0]  set_tag,
    input  logic     [NCMT-1:0]   clr_en,
    input  reg_idx_t [NCMT-1:0]   clr_idx,
    input  rob_tag_t [NCMT-1:0]   clr_tag,
    input  logic                  flush,
    output logic [NREG-1:0]       busy,
    output logic [NREG*TAGW-1:0]  tag_flat
);

    logic [NREG-1:0] busy_q, busy_d;
    rob_tag_t        tag_q [NREG];
    rob_tag_t        tag_d [NREG];
    logic            set_hit, clr_hit;

    always_comb begin
        // NOTE: every variable gets a value before any branch so no path leaves it
        // unassigned; that is what keeps this block from inferring latches.
        busy_d  = busy_q;
        set_hit = 1'b0;
        clr_hit = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            set_hit  = 1'b0;
            clr_hit  = 1'b0;
            tag_d[r] = tag_q[r];
            // Later (younger) slots overwrite earlier ones, so D beats C beats B beats A.
            for (int s = 0; s < NDISP; s++) begin
                if (set_en[s] && set_idx[s] == reg_idx_t'(r)) begin
                    set_hit  = 1'b1;
                    tag_d[r] = set_tag[s];
                end
            end
            for (int k = 0; k < NCMT; k++) begin
                if (clr_en[k] && clr_idx[k] == reg_idx_t'(r) && clr_tag[k] == tag_q[r]) begin
                    clr_hit = 1'b1;
                end
            end
            if (flush)        busy_d[r] = 1'b0;
            else if (set_hit) busy_d[r] = 1'b1;
            else if (clr_hit) busy_d[r] = 1'b0;
            else              busy_d[r] = busy_q[r];
        end
    end

    // NOTE: the tag array is a handful of flops, not a RAM macro, so it takes the
    // async reset like any other state and comes up as all-zero tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                tag_q[r] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            busy_q <= busy_d;
            for (int r = 0; r < NREG; r++) begin
                tag_q[r] <= tag_d[r];
            end
        end
    end

    always_comb begin
        tag_flat = '0;
        for (int r = 0; r < NREG; r++) begin
            tag_flat[r*TAGW +: TAGW] = tag_q[r];
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/reg_status_ctrl.sv
// Rename/commit controller: RUN/FLUSH sequencing, register-file write-port gating
// and busy popcount around the busy/tag table.
module reg_status_ctrl
    import reg_status_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    reg_status_ctrl_if.slave bus
);

    state_t          state_q, state_d;
    logic            disp_ready;
    logic [NDISP-1:0] disp_acc;
    logic [NREG-1:0] busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Each flushing cycle buys exactly one more FLUSH cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = bus.flush ? FLUSH : RUN;
            FLUSH:   state_d = bus.flush ? FLUSH : RUN;
            default: state_d = RUN;
        endcase
    end

    // Combinational so that a flush in the same cycle kills dispatch.
    assign disp_ready     = (state_q == RUN) && !bus.flush;
    assign disp_acc       = bus.disp_valid & {NDISP{disp_ready}};

    assign bus.disp_ready = disp_ready;
    assign bus.rob_wen    = disp_acc;
    assign bus.rob_waddr  = bus.disp_waddr;
    assign bus.rob_loc    = bus.disp_loc;

    // Retirements are older than any flush, so data writes are never gated.
    assign bus.wen        = bus.cmt_valid;
    assign bus.waddr      = bus.cmt_waddr;
    assign bus.wdata      = bus.cmt_data;

    busy_tag_table u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (disp_acc),
        .set_idx  (bus.disp_waddr),
        .set_tag  (bus.disp_loc),
        .clr_en   (bus.cmt_valid),
        .clr_idx  (bus.cmt_waddr),
        .clr_tag  (bus.cmt_loc),
        .flush    (bus.flush),
        .busy     (busy),
        .tag_flat (bus.tag_flat)
    );

    assign bus.busy       = busy;
    assign bus.busy_count = popcount(busy);
    assign bus.flushing   = (state_q == FLUSH);

endmodule

// File: tb/tb_reg_status_ctrl.sv
// Directed bench for reg_status_ctrl: stimulus pushes hand-computed expectations into a
// scoreboard queue, a negedge monitor pops and compares them against the DUT.
module tb_reg_status_ctrl;
    import reg_status_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_status_ctrl_if bus ();

    reg_status_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Expectations for one cycle: combinational outputs for this cycle's inputs, and the
    // registered state visible during this cycle (i.e. produced by the previous edge).
    typedef struct {
        string                 name;
        reg_idx_t  [NDISP-1:0] dw;
        rob_tag_t  [NDISP-1:0] dl;
        reg_idx_t  [NCMT-1:0]  cw;
        reg_data_t [NCMT-1:0]  cd;
        logic                  e_ready;
        logic      [NDISP-1:0] e_rwen;
        logic      [NCMT-1:0]  e_wen;
        logic      [NREG-1:0]  e_busy;
        logic                  e_flushing;
        int                    tr;
        rob_tag_t              e_tag;
        int                    rf_r;
        reg_data_t             rf_v;
    } exp_t;

    exp_t sb [$];
    exp_t cur;

    int n_checks = 0;
    int n_errors = 0;

    // Staged stimulus for the next step().
    logic      [NDISP-1:0] s_dv;
    reg_idx_t  [NDISP-1:0] s_dw;
    rob_tag_t  [NDISP-1:0] s_dl;
    logic      [NCMT-1:0]  s_cv;
    reg_idx_t  [NCMT-1:0]  s_cw;
    rob_tag_t  [NCMT-1:0]  s_cl;
    reg_data_t [NCMT-1:0]  s_cd;

    // Register file model: ports written in order, youngest port wins.
    reg_data_t rf [NREG];
    always @(posedge clk) begin
        for (int k = 0; k < NCMT; k++) begin
            if (bus.wen[k]) rf[bus.waddr[k]] <= bus.wdata[k];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_stage();
        s_dv = '0; s_dw = '0; s_dl = '0;
        s_cv = '0; s_cw = '0; s_cl = '0; s_cd = '0;
    endtask

    task automatic disp(input int s, input int r, input int t);
        s_dv[s] = 1'b1;
        s_dw[s] = reg_idx_t'(r);
        s_dl[s] = rob_tag_t'(t);
    endtask

    task automatic cmt(input int k, input int r, input int t, input int d);
        s_cv[k] = 1'b1;
        s_cw[k] = reg_idx_t'(r);
        s_cl[k] = rob_tag_t'(t);
        s_cd[k] = reg_data_t'(d);
    endtask

    task automatic step(input string name, input logic fl, input logic e_ready,
                        input logic [3:0] e_rwen, input logic [2:0] e_wen,
                        input logic [7:0] e_busy, input logic e_flushing,
                        input int tr, input int e_tag,
                        input int rf_r = -1, input int rf_v = 0);
        exp_t e;
        @(posedge clk);
        #1;
        bus.disp_valid = s_dv; bus.disp_waddr = s_dw; bus.disp_loc = s_dl;
        bus.cmt_valid  = s_cv; bus.cmt_waddr  = s_cw; bus.cmt_loc  = s_cl;
        bus.cmt_data   = s_cd; bus.flush      = fl;
        e.name = name; e.dw = s_dw; e.dl = s_dl; e.cw = s_cw; e.cd = s_cd;
        e.e_ready = e_ready; e.e_rwen = e_rwen; e.e_wen = e_wen;
        e.e_busy = e_busy; e.e_flushing = e_flushing;
        e.tr = tr; e.e_tag = rob_tag_t'(e_tag);
        e.rf_r = rf_r; e.rf_v = reg_data_t'(rf_v);
        sb.push_back(e);
        clear_stage();
    endtask

    always @(negedge clk) begin
        if (rst_n && sb.size() > 0) begin
            cur = sb.pop_front();
            check({cur.name, ".disp_ready"}, 64'(bus.disp_ready), 64'(cur.e_ready));
            check({cur.name, ".rob_wen"},    64'(bus.rob_wen),    64'(cur.e_rwen));
            check({cur.name, ".wen"},        64'(bus.wen),        64'(cur.e_wen));
            check({cur.name, ".busy"},       64'(bus.busy),       64'(cur.e_busy));
            check({cur.name, ".busy_count"}, 64'(bus.busy_count), 64'($countones(cur.e_busy)));
            check({cur.name, ".flushing"},   64'(bus.flushing),   64'(cur.e_flushing));
            check({cur.name, ".tag"},        64'(bus.tag_flat[cur.tr*TAGW +: TAGW]), 64'(cur.e_tag));
            for (int s = 0; s < NDISP; s++) begin
                if (cur.e_rwen[s]) begin
                    check({cur.name, ".rob_waddr"}, 64'(bus.rob_waddr[s]), 64'(cur.dw[s]));
                    check({cur.name, ".rob_loc"},   64'(bus.rob_loc[s]),   64'(cur.dl[s]));
                end
            end
            for (int k = 0; k < NCMT; k++) begin
                if (cur.e_wen[k]) begin
                    check({cur.name, ".waddr"}, 64'(bus.waddr[k]), 64'(cur.cw[k]));
                    check({cur.name, ".wdata"}, 64'(bus.wdata[k]), 64'(cur.cd[k]));
                end
            end
            if (cur.rf_r >= 0) begin
                check({cur.name, ".rf"}, 64'(rf[cur.rf_r]), 64'(cur.rf_v));
            end
        end
    end

    initial begin
        int wait_cycles;
        for (int r = 0; r < NREG; r++) rf[r] = '0;
        clear_stage();
        bus.disp_valid = '0; bus.disp_waddr = '0; bus.disp_loc = '0;
        bus.cmt_valid  = '0; bus.cmt_waddr  = '0; bus.cmt_loc  = '0;
        bus.cmt_data   = '0; bus.flush      = 1'b0;
        #12 rst_n = 1'b1;

        //   name            fl rdy rob_wen wen     busy   fl'ing tr tag  rf
        step("reset_idle",    0, 1, 4'b0000, 3'b000, 8'h00, 0, 0, 0);
        disp(0, 3, 5);
        step("disp_a_r3",     0, 1, 4'b0001, 3'b000, 8'h00, 0, 3, 0);
        step("r3_busy",       0, 1, 4'b0000, 3'b000, 8'h08, 0, 3, 5);
        disp(0, 2, 7); disp(2, 2, 9);
        step("disp_ac_r2",    0, 1, 4'b0101, 3'b000, 8'h08, 0, 3, 5);
        cmt(0, 2, 7, 16'h1111);
        step("cmt_r2_stale",  0, 1, 4'b0000, 3'b001, 8'h0C, 0, 2, 9);
        cmt(0, 2, 9, 16'h2222); disp(0, 4, 6);
        step("cmt_r2_match",  0, 1, 4'b0001, 3'b001, 8'h0C, 0, 2, 9, 2, 16'h1111);
        cmt(0, 4, 6, 16'h4444); disp(3, 4, 11);
        step("cmt_disp_r4",   0, 1, 4'b1000, 3'b001, 8'h18, 0, 4, 6, 2, 16'h2222);
        disp(0, 1, 1); disp(1, 5, 2); disp(2, 6, 3);
        step("r4_retag",      0, 1, 4'b0111, 3'b000, 8'h18, 0, 4, 11, 4, 16'h4444);
        disp(0, 0, 20);
        step("flush_kill",    1, 0, 4'b0000, 3'b000, 8'h7A, 0, 5, 2);
        disp(0, 0, 20); cmt(1, 3, 5, 16'h3333);
        step("in_flush",      0, 0, 4'b0000, 3'b010, 8'h00, 1, 4, 11);
        step("back_run",      0, 1, 4'b0000, 3'b000, 8'h00, 0, 0, 0, 3, 16'h3333);
        step("flush_1",       1, 0, 4'b0000, 3'b000, 8'h00, 0, 0, 0);
        step("flush_2",       1, 0, 4'b0000, 3'b000, 8'h00, 1, 0, 0);
        step("flush_ext",     0, 0, 4'b0000, 3'b000, 8'h00, 1, 0, 0);
        step("flush_done",    0, 1, 4'b0000, 3'b000, 8'h00, 0, 0, 0);
        disp(0, 7, 12);
        step("disp_r7",       0, 1, 4'b0001, 3'b000, 8'h00, 0, 7, 0);
        cmt(0, 7, 12, 16'hAAAA); cmt(2, 7, 13, 16'hBBBB);
        step("cmt_r7_dual",   0, 1, 4'b0000, 3'b101, 8'h80, 0, 7, 12);
        step("r7_cleared",    0, 1, 4'b0000, 3'b000, 8'h00, 0, 7, 12, 7, 16'hBBBB);
        disp(0, 0, 1); disp(1, 1, 2); disp(2, 2, 3); disp(3, 3, 4);
        step("fill_lo",       0, 1, 4'b1111, 3'b000, 8'h00, 0, 0, 0);
        disp(0, 4, 5); disp(1, 5, 6); disp(2, 6, 7); disp(3, 7, 8);
        step("fill_hi",       0, 1, 4'b1111, 3'b000, 8'h0F, 0, 2, 3);
        step("all_busy",      0, 1, 4'b0000, 3'b000, 8'hFF, 0, 7, 8);

        @(posedge clk);
        #1;
        bus.disp_valid = '0; bus.cmt_valid = '0; bus.flush = 1'b0;

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 100) begin
            @(posedge clk);
            wait_cycles++;
        end
        check("scoreboard_drain", 64'(sb.size()), 64'd0);

        // Reset dropped between edges with every register busy.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst.busy",       64'(bus.busy),       64'd0);
        check("async_rst.busy_count", 64'(bus.busy_count), 64'd0);
        check("async_rst.tag_flat",   64'(bus.tag_flat),   64'd0);
        check("async_rst.flushing",   64'(bus.flushing),   64'd0);
        check("async_rst.disp_ready", 64'(bus.disp_ready), 64'd1);
        #10;
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
